serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract unit. Two WIDTH-bit operands are accepted over a
//   valid/ready handshake, pushed LSB-first through a single 1-bit full adder
//   (one bit per clock, carry kept in a register), and the WIDTH-bit result is
//   returned with unsigned carry and signed overflow flags over a second
//   valid/ready handshake. No pipelining: one operation in flight at a time.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  controller can accept operands (IDLE)
//   op_a       in   operand A   (sampled on input handshake)
//   op_b       in   operand B   (sampled on input handshake)
//   sub        in   0 = A+B, 1 = A-B (sampled on input handshake)
//   out_valid  out  result/carry_out/overflow valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  sum/difference, modulo 2^WIDTH
//   carry_out  out  final carry; for subtract 1 = no borrow
//   overflow   out  signed overflow
//   busy       out  high in RUN and DONE
// ---------------------------------------------------------------------------

// 1-bit full adder used as the arithmetic core of the serial unit.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sum bits produced so far; the final bit is merged
  // directly into result on the last RUN cycle.
  logic [WIDTH-2:0] res_sr;
  logic             carry_reg;
  logic [CW-1:0]    count;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;

  fulladder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB and everything moves one place right, so
  // after WIDTH steps the first (LSB) sum bit has reached bit 0.
  assign res_next = {fa_sum, res_sr};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // Subtraction is A + ~B + 1: B is inverted on load and the carry register
  // is preset with sub. On the last bit, carry_reg is the carry into the MSB,
  // so overflow is carry-in(MSB) XOR carry-out(MSB).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= op_a;
            b_sr      <= sub ? ~op_b : op_b;
            carry_reg <= sub;
            count     <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          res_sr    <= res_next[WIDTH-1:1];
          carry_reg <= fa_carry;
          count     <= count + 1'b1;
          if (count == LAST_BIT) begin
            result    <= res_next;
            carry_out <= fa_carry;
            overflow  <= carry_reg ^ fa_carry;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Scoreboard bench for serial_adder_ctrl. The driver pushes the expected
//   response of every accepted operation into a queue; an independent monitor
//   pops and compares whenever an output handshake occurs. Expected values
//   come from a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W       = 8;
  localparam int TIMEOUT = 4 * W + 20;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int   checks;
  int   errors;
  exp_t sb_q[$];
  time  accept_time;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact integer arithmetic, then wrap and range-check.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
    exp_t   e;
    longint ua, ub, sa, sb, us, ss, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (s) begin
      us  = ua - ub;
      ss  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      us  = ua + ub;
      ss  = sa + sb;
      e.c = ((us >>> W) != 0);
    end
    e.res = us[W-1:0];
    e.v   = (ss > smax) || (ss < smin);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_output("result", 32'(result), 32'(e.res));
        check_output("carry_out", 32'(carry_out), 32'(e.c));
        check_output("overflow", 32'(overflow), 32'(e.v));
      end
    end
  end

  // Present operands from posedge+1 and wait for acceptance; the expected
  // response is pushed at the negedge where in_ready is seen high.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input bit keep);
    bit ok;
    ok       = 1'b0;
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    for (int n = 0; n < TIMEOUT && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(a, b, s));
        accept_time = $time;
        ok = 1'b1;
      end
    end
    check_output("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Raise out_ready after an optional delay, wait for the output handshake,
  // then confirm out_valid drops and in_ready is back the next cycle.
  task automatic drain(input int delay);
    bit got;
    got = 1'b0;
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int n = 0; n < TIMEOUT && !got; n++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check_output("result_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_output("out_valid_drop", 32'(out_valid), 32'd0);
    check_output("in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int delay);
    apply_stimulus(a, b, s, 1'b0);
    drain(delay);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   early;
    bit   seen;
    exp_t e;
    time  prev_accept;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_result", 32'(result), 32'd0);
    check_output("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 0x3C+0x45 with exact latency: out_valid low for W negedges after the
    // accepting edge, high on the next one.
    apply_stimulus(8'h3C, 8'h45, 1'b0, 1'b0);
    early = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
      if (i == 0) check_output("busy_run", 32'(busy), 32'd1);
    end
    check_output("latency_early", 32'(early), 32'd0);
    @(negedge clk);
    check_output("latency_rise", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain(0);

    // Directed edge cases
    do_op(8'h05, 8'h07, 1'b1, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1);
    do_op(8'h80, 8'h01, 1'b1, 0);

    // Backpressure: hold DONE for 5 cycles with in_valid pulses
    apply_stimulus(8'hA5, 8'h3C, 1'b1, 1'b0);
    e    = model(8'hA5, 8'h3C, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < TIMEOUT && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_output("bp_wait", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      sub      = 1'($urandom);
      @(negedge clk);
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      check_output("bp_result", 32'(result), 32'(e.res));
      check_output("bp_flags", {30'd0, carry_out, overflow}, {30'd0, e.c, e.v});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(0);
    do_op(8'h10, 8'h20, 1'b0, 0);

    // Reset mid-RUN aborts the operation
    apply_stimulus(8'h55, 8'h0F, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_result", 32'(result), 32'd0);
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    do_op(8'h7F, 8'h01, 1'b0, 0);

    // Back-to-back: in_valid and out_ready held high, W+2 cycles per result
    out_ready   = 1'b1;
    prev_accept = 0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      if (i > 0) check_output("throughput", 32'(accept_time - prev_accept), 32'((W + 2) * 10));
      prev_accept = accept_time;
    end
    in_valid = 1'b0;
    for (int n = 0; n < TIMEOUT && sb_q.size() != 0; n++) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Randomized operations with random consumer delay
    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
